sar_search_ctrl: RTL

//  Successive-approximation search controller wrapped around the magnitude comparator.
//  - Drives a trial code onto the comparator's b input; the unknown target sits on a.
//  - Consumes the comparator's eq/lt/gt flags each cycle.
//  - Converges on the largest code <= target in at most WIDTH cycles, then reports it

---
 rtl/sar_pkg.sv | 17 +
 rtl/sar_search_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search controller:
// state encodings and the default code width.
package sar_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int SAR_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SEARCH = ST_SEARCH,
    S_DONE   = ST_DONE
  } sar_state_e;

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial codes to an external
// magnitude comparator and converges on the target with a start/busy/done handshake.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_e       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [WIDTH-1:0] trial_nxt, result_nxt;
  logic             exact_nxt, err_nxt;

  function automatic logic [WIDTH-1:0] msb_code();
    return {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= PTR_W'(WIDTH-1);
      trial  <= '0;
      result <= '0;
      exact  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      trial  <= trial_nxt;
      result <= result_nxt;
      exact  <= exact_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    trial_nxt  = trial;
    result_nxt = result;
    exact_nxt  = exact;
    err_nxt    = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SEARCH;
          trial_nxt = msb_code();
          ptr_nxt   = PTR_W'(WIDTH-1);
          exact_nxt = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      S_SEARCH: begin
        // Flags must be exactly one-hot; anything else aborts with err.
        case ({cmp_eq, cmp_lt, cmp_gt})
          3'b100: begin
            result_nxt = trial;
            exact_nxt  = 1'b1;
            state_nxt  = S_DONE;
          end
          3'b010, 3'b001: begin
            trial_nxt[ptr] = cmp_gt;
            if (ptr != '0) begin
              trial_nxt[ptr - 1'b1] = 1'b1;
              ptr_nxt               = ptr - 1'b1;
            end else begin
              result_nxt = trial_nxt;
              exact_nxt  = 1'b0;
              state_nxt  = S_DONE;
            end
          end
          default: begin
            err_nxt    = 1'b1;
            result_nxt = trial;
            state_nxt  = S_DONE;
          end
        endcase
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_SEARCH);
  assign done = (state == S_DONE);

endmodule
